// File: rtl/wdg_timer.sv
// Watchdog timebase: prescaler divides clk into ticks, the main counter counts
// ticks down from the shadowed timeout and emits a one-cycle count0 on expiry.
module wdg_timer #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             do_cnt,
    input  logic             clr,
    input  logic [CNT_W-1:0] tov,
    input  logic [PRE_W-1:0] pre,
    output logic             count0,
    output logic [CNT_W-1:0] cnt,
    output logic             running
);

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] tov_sh_q, tov_sh_d;
    logic [PRE_W-1:0] pre_sh_q, pre_sh_d;
    logic             count0_q, count0_d;
    logic             load;
    logic             tick;

    // Any of these holds the counter parked at the programmed values.
    assign load = clr | ~en | ~do_cnt;
    assign tick = (pre_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ST_STOP;
            cnt_q     <= '0;
            pre_cnt_q <= '0;
            tov_sh_q  <= '0;
            pre_sh_q  <= '0;
            count0_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_cnt_q <= pre_cnt_d;
            tov_sh_q  <= tov_sh_d;
            pre_sh_q  <= pre_sh_d;
            count0_q  <= count0_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_cnt_d = pre_cnt_q;
        tov_sh_d  = tov_sh_q;
        pre_sh_d  = pre_sh_q;
        count0_d  = 1'b0;
        if (load) begin
            // Load beats a coincident expiry, so a re-arm never leaks a count0.
            state_d   = ST_STOP;
            cnt_d     = tov;
            pre_cnt_d = pre;
            tov_sh_d  = tov;
            pre_sh_d  = pre;
        end else begin
            state_d = ST_RUN;
            if (tick) begin
                pre_cnt_d = pre_sh_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Self-reload gives the second stage a full period.
                    cnt_d    = tov_sh_q;
                    count0_d = 1'b1;
                end
            end else begin
                pre_cnt_d = pre_cnt_q - PRE_W'(1);
            end
        end
    end

    assign count0  = count0_q;
    assign cnt     = cnt_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_wdg_timer.sv
// Scoreboarded bench for wdg_timer: an elapsed-cycle reference model pushes the
// expected outputs per edge; a negedge monitor pops and compares.
module tb_wdg_timer;
    localparam int CNT_W = 32;
    localparam int PRE_W = 16;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             en = 1'b0;
    logic             do_cnt = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] tov = '0;
    logic [PRE_W-1:0] pre = '0;
    logic             count0;
    logic [CNT_W-1:0] cnt;
    logic             running;

    wdg_timer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .res(res), .en(en), .do_cnt(do_cnt), .clr(clr),
        .tov(tov), .pre(pre), .count0(count0), .cnt(cnt), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             c0;
        logic [CNT_W-1:0] cnt;
        logic             run;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: period (T+1)*(P+1) counting cycles; k = counting cycles since load.
    longint unsigned m_t = 0, m_p = 0, m_k = 0;
    bit              m_c0 = 0, m_run = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (res) begin
            m_t = 0; m_p = 0; m_k = 0; m_c0 = 0; m_run = 0;
        end else if (clr || !en || !do_cnt) begin
            m_t = longint'(tov); m_p = longint'(pre); m_k = 0; m_c0 = 0; m_run = 0;
        end else begin
            m_run = 1;
            m_k++;
            if (m_k == (m_t + 1) * (m_p + 1)) begin
                m_k  = 0;
                m_c0 = 1;
            end else begin
                m_c0 = 0;
            end
        end
        e.c0  = m_c0;
        e.cnt = CNT_W'(m_t - m_k / (m_p + 1));
        e.run = m_run;
        q.push_back(e);
        #1;
    endtask

    // Steps with inputs held until the DUT shows count0; returns cycles taken.
    task automatic wait_c0(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!count0 && n < limit);
        if (!count0) begin
            n_bad++;
            $display("FAIL wait_count0: no count0 within %0d cycles", limit);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("count0", longint'(count0), longint'(e.c0));
                check("cnt", longint'(cnt), longint'(e.cnt));
                check("running", longint'(running), longint'(e.run));
            end
        end
    end

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int n;
        int n2;
        step(); step();
        res = 1'b0;
        check("reset_cnt", longint'(cnt), 0);

        // Basic expiry: tov=3, pre=1 -> count0 after 8 cycles
        tov = 3; pre = 1; en = 1; do_cnt = 0; step();
        do_cnt = 1; wait_c0(40, n); check("basic_latency", n, 8);

        // Prescaler bypass, twice across a one-cycle do_cnt drop
        tov = 0; pre = 0; do_cnt = 0; step();
        do_cnt = 1; wait_c0(10, n); check("bypass_latency1", n, 1);
        do_cnt = 0; step();
        do_cnt = 1; wait_c0(10, n); check("bypass_latency2", n, 1);

        // Re-arm race: clr on the expiry tick
        tov = 2; pre = 0; do_cnt = 0; step();
        do_cnt = 1; step(); step();
        clr = 1; step();
        check("race_count0", longint'(count0), 0);
        check("race_cnt", longint'(cnt), 2);
        clr = 0; wait_c0(20, n); check("race_latency", n, 3);

        // Shadowing: tov change mid-count ignored until next load
        tov = 5; pre = 0; do_cnt = 0; step();
        do_cnt = 1; step(); step();
        tov = 1; wait_c0(20, n2); check("shadow_latency", n2 + 2, 6);
        do_cnt = 0; step();
        do_cnt = 1; wait_c0(20, n); check("shadow_new_latency", n, 2);

        // Enable drop and reset mid-count
        tov = 6; pre = 1; do_cnt = 0; step();
        do_cnt = 1; repeat (5) step();
        en = 0; step();
        check("abort_cnt", longint'(cnt), 6);
        check("abort_running", longint'(running), 0);
        en = 1; repeat (4) step();
        res = 1; step();
        check("reset_mid_cnt", longint'(cnt), 0);
        check("reset_mid_running", longint'(running), 0);
        res = 0; do_cnt = 0; step();

        // Two-stage sequence as the FSM would drive it
        tov = 4; pre = 2; step();
        do_cnt = 1; wait_c0(40, n); check("stage1_latency", n, 15);
        do_cnt = 0; step();
        do_cnt = 1; wait_c0(40, n); check("stage2_latency", n, 15);
        do_cnt = 0; repeat (4) step();
        check("s2_hold_cnt", longint'(cnt), 4);

        // Randomized traffic, with occasional all-ones programming
        for (int i = 0; i < 3000; i++) begin
            res    = ($urandom_range(0, 199) == 0);
            clr    = ($urandom_range(0, 99) < 3);
            en     = ($urandom_range(0, 99) >= 3);
            do_cnt = ($urandom_range(0, 99) >= 6);
            if ($urandom_range(0, 9) == 0) begin
                tov = CNT_W'($urandom_range(0, 12));
                pre = PRE_W'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 499) == 0) begin
                tov = '1;
                pre = '1;
            end
            step();
        end
        res = 0; clr = 0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
